// File: rtl/sequence_checker.sv
// Player side of the Simon interface: stores the played sequence, debounces the
// raw buttons and checks each accepted press against the stored step.
module sequence_checker #(
  parameter int unsigned MAX_LEN   = 32,
  parameter int unsigned DB_CYCLES = 4,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btns,
  input  logic       seq_wr,
  input  logic [1:0] seq_num,
  input  logic       seq_clear,
  input  logic       round_start,
  output logic [1:0] player_num,
  output logic       player_pressed,
  output logic       round_done,
  output logic       game_over,
  output logic       player_turn,
  output logic [5:0] score,
  output logic       overflow
);

  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned DW = $clog2(DB_CYCLES + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [5:0]  LEN_MAX = 6'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, FAIL} state_t;

  state_t        state_q;
  logic [1:0]    mem_q [2**IW];
  logic [5:0]    len_q, idx_q, score_q;
  logic [TW-1:0] tcnt_q, tick_d;
  logic [3:0]    samp_q, samp_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [1:0]    num_q, press_k, step;
  logic          pressed_q, done_q, over_q, turn_q, ovf_q;
  logic          stable, press_ok, release_ok, timeout_hit;

  // The counter value after this edge says how many consecutive edges the
  // present pattern has been seen, so the FSM can act on the same edge.
  always_comb begin
    samp_d = btns;
    if (btns == samp_q) begin
      cnt_d = (cnt_q == DW'(DB_CYCLES)) ? cnt_q : cnt_q + 1'b1;
    end else begin
      cnt_d = DW'(1);
    end
  end

  always_comb begin
    press_k = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (btns[i]) press_k = 2'(i);
    end
  end

  assign stable      = (cnt_d == DW'(DB_CYCLES));
  assign press_ok    = stable && $onehot(btns);
  assign release_ok  = stable && (btns == '0);
  assign step        = mem_q[idx_q[IW-1:0]];
  assign tick_d      = tcnt_q + 1'b1;
  assign timeout_hit = (TIMEOUT != 0) && (tick_d == TW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (!reset) begin
      samp_q <= '0;
      cnt_q  <= '0;
    end else begin
      samp_q <= samp_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !seq_clear && state_q == IDLE && seq_wr && len_q != LEN_MAX) begin
      mem_q[len_q[IW-1:0]] <= seq_num;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      tcnt_q    <= '0;
      num_q     <= '0;
      pressed_q <= 1'b0;
      done_q    <= 1'b0;
      over_q    <= 1'b0;
      turn_q    <= 1'b0;
      score_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (seq_clear) begin
        state_q   <= IDLE;
        len_q     <= '0;
        idx_q     <= '0;
        score_q   <= '0;
        over_q    <= 1'b0;
        ovf_q     <= 1'b0;
        pressed_q <= 1'b0;
        turn_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (seq_wr) begin
              if (len_q == LEN_MAX) ovf_q <= 1'b1;
              else                  len_q <= len_q + 1'b1;
            end
            if (round_start && len_q != '0) begin
              state_q <= WAIT_PRESS;
              idx_q   <= '0;
              tcnt_q  <= '0;
              turn_q  <= 1'b1;
            end
          end
          WAIT_PRESS: begin
            tcnt_q <= tick_d;
            if (press_ok) begin
              if (press_k == step) begin
                state_q   <= WAIT_RELEASE;
                num_q     <= press_k;
                pressed_q <= 1'b1;
              end else begin
                state_q <= FAIL;
                over_q  <= 1'b1;
                turn_q  <= 1'b0;
              end
            end else if (timeout_hit) begin
              state_q <= FAIL;
              over_q  <= 1'b1;
              turn_q  <= 1'b0;
            end
          end
          WAIT_RELEASE: begin
            if (release_ok) begin
              pressed_q <= 1'b0;
              idx_q     <= idx_q + 1'b1;
              if (idx_q + 1'b1 == len_q) begin
                done_q  <= 1'b1;
                score_q <= len_q;
                state_q <= IDLE;
                turn_q  <= 1'b0;
              end else begin
                state_q <= WAIT_PRESS;
                tcnt_q  <= '0;
              end
            end
          end
          FAIL: ;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign player_num     = num_q;
  assign player_pressed = pressed_q;
  assign round_done     = done_q;
  assign game_over      = over_q;
  assign player_turn    = turn_q;
  assign score          = score_q;
  assign overflow       = ovf_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Bench for sequence_checker: directed scenarios plus random play, all compared
// every cycle against a queue-based behavioural model of the game rules.
module tb_sequence_checker;

  localparam int unsigned MAXL = 4;
  localparam int unsigned DB   = 4;
  localparam int unsigned TO   = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btns = '0;
  logic       seq_wr = 1'b0;
  logic [1:0] seq_num = '0;
  logic       seq_clear = 1'b0;
  logic       round_start = 1'b0;
  logic [1:0] player_num;
  logic       player_pressed, round_done, game_over, player_turn, overflow;
  logic [5:0] score;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  sequence_checker #(.MAX_LEN(MAXL), .DB_CYCLES(DB), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(rst_n), .btns(btns), .seq_wr(seq_wr), .seq_num(seq_num),
    .seq_clear(seq_clear), .round_start(round_start), .player_num(player_num),
    .player_pressed(player_pressed), .round_done(round_done), .game_over(game_over),
    .player_turn(player_turn), .score(score), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Behavioural model: the game as a queue of steps plus a window of recent samples.
  typedef enum int {M_IDLE, M_PRESS, M_HELD, M_LOST} mphase_t;
  mphase_t    m_phase = M_IDLE;
  logic [1:0] m_seq[$];
  logic [3:0] hist[$];
  int         m_idx = 0, m_tick = 0;
  logic [1:0] m_num = '0;
  logic       m_pressed = 0, m_done = 0, m_over = 0, m_ovf = 0;
  logic [5:0] m_score = '0;

  always @(posedge clk) begin
    bit stable;
    int k;
    int old_len;
    if (!rst_n) begin
      m_phase = M_IDLE; m_seq.delete(); hist.delete();
      m_idx = 0; m_tick = 0; m_num = '0; m_pressed = 0; m_done = 0;
      m_over = 0; m_ovf = 0; m_score = '0;
    end else begin
      hist.push_back(btns);
      if (hist.size() > DB) void'(hist.pop_front());
      stable = (hist.size() == DB);
      foreach (hist[i]) if (hist[i] != btns) stable = 0;
      k = 0;
      for (int i = 0; i < 4; i++) if (btns[i]) k = i;
      m_done = 0;
      if (seq_clear) begin
        m_seq.delete(); m_score = '0; m_over = 0; m_ovf = 0;
        m_phase = M_IDLE; m_pressed = 0; m_idx = 0;
      end else begin
        case (m_phase)
          M_IDLE: begin
            old_len = m_seq.size();
            if (seq_wr) begin
              if (m_seq.size() < MAXL) m_seq.push_back(seq_num);
              else m_ovf = 1;
            end
            if (round_start && old_len != 0) begin
              m_phase = M_PRESS; m_idx = 0; m_tick = 0;
            end
          end
          M_PRESS: begin
            m_tick++;
            if (stable && $countones(btns) == 1) begin
              if (k == int'(m_seq[m_idx])) begin
                m_phase = M_HELD; m_num = 2'(k); m_pressed = 1;
              end else begin
                m_phase = M_LOST; m_over = 1;
              end
            end else if (m_tick == TO) begin
              m_phase = M_LOST; m_over = 1;
            end
          end
          M_HELD: begin
            if (stable && btns == 4'b0000) begin
              m_pressed = 0;
              m_idx++;
              if (m_idx == m_seq.size()) begin
                m_done = 1; m_score = 6'(m_seq.size()); m_phase = M_IDLE;
              end else begin
                m_phase = M_PRESS; m_tick = 0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    logic [12:0] act, exp;
    if (cmp_en) begin
      act = {player_num, player_pressed, round_done, game_over, player_turn, score, overflow};
      exp = {m_num, m_pressed, m_done, m_over,
             1'(m_phase == M_PRESS || m_phase == M_HELD), m_score, m_ovf};
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t num/prs/done/over/turn/score/ovf got %b required %b",
                 $time, act, exp);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got %0d required %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] v);
    seq_wr = 1; seq_num = v; tick(1); seq_wr = 0;
  endtask

  task automatic start();
    round_start = 1; tick(1); round_start = 0;
  endtask

  task automatic clear();
    seq_clear = 1; tick(1); seq_clear = 0;
  endtask

  task automatic press_release(input int k, input bit last, input string tag);
    btns = 4'b0001 << k; tick(DB);
    chk({tag, "_pressed"}, player_pressed, 1);
    chk({tag, "_num"}, player_num, k);
    btns = '0; tick(DB);
    chk({tag, "_released"}, player_pressed, 0);
    chk({tag, "_done"}, round_done, int'(last));
  endtask

  initial begin
    logic [3:0] pat;
    int r;
    // 1: reset and first round start
    tick(1); cmp_en = 1; tick(1);
    chk("rst_outputs", {player_num, player_pressed, round_done, game_over, player_turn, score, overflow}, 0);
    rst_n = 1;
    wr(2); wr(0); wr(3);
    start();
    chk("turn_after_start", player_turn, 1);
    // 2: correct three-step round
    press_release(2, 0, "s2a");
    press_release(0, 0, "s2b");
    press_release(3, 1, "s2c");
    chk("s2_score", score, 3);
    tick(1);
    chk("s2_done_pulse", round_done, 0);
    chk("s2_idle", player_turn, 0);
    // 3: wrong colour
    clear(); wr(1); start();
    btns = 4'b0100; tick(DB);
    chk("s3_over", game_over, 1);
    chk("s3_no_press", player_pressed, 0);
    btns = '0; start();
    chk("s3_start_ignored", player_turn, 0);
    chk("s3_still_over", game_over, 1);
    clear();
    chk("s3_cleared", game_over, 0);
    // 4: glitch and multi-bit patterns
    wr(1); start();
    btns = 4'b0010; tick(3);
    btns = 4'b0000; tick(1);
    chk("s4_glitch", player_pressed, 0);
    btns = 4'b0110; tick(10);
    chk("s4_multi_press", player_pressed, 0);
    chk("s4_multi_over", game_over, 0);
    press_release(1, 1, "s4");
    chk("s4_score", score, 1);
    // 5: overflow, full-length round, timeout
    clear();
    wr(0); wr(1); wr(2); wr(3);
    chk("s5_no_ovf", overflow, 0);
    wr(0);
    chk("s5_ovf", overflow, 1);
    start();
    press_release(0, 0, "s5a");
    press_release(1, 0, "s5b");
    press_release(2, 0, "s5c");
    press_release(3, 1, "s5d");
    chk("s5_score", score, 4);
    start(); tick(TO - 1);
    chk("s5_before_timeout", game_over, 0);
    tick(1);
    chk("s5_timeout", game_over, 1);
    // 6: reset while a press is held
    clear(); wr(3); start();
    btns = 4'b1000; tick(DB);
    chk("s6_held", player_pressed, 1);
    rst_n = 0; btns = '0; tick(1);
    chk("s6_rst_outputs", {player_num, player_pressed, round_done, game_over, player_turn, score, overflow}, 0);
    rst_n = 1; start();
    chk("s6_len_zero", player_turn, 0);
    // random play
    for (int s = 0; s < 1500; s++) begin
      r = $urandom_range(0, 99);
      if (r < 8) wr(2'($urandom_range(0, 3)));
      else if (r < 15) start();
      else if (r < 19) clear();
      else if (r < 20) begin rst_n = 0; tick(1); rst_n = 1; end
      else begin
        r = $urandom_range(0, 99);
        if (r < 40 && m_phase == M_PRESS && m_idx < m_seq.size()) pat = 4'b0001 << m_seq[m_idx];
        else if (r < 65) pat = 4'b0000;
        else if (r < 85) pat = 4'b0001 << $urandom_range(0, 3);
        else pat = 4'($urandom_range(0, 15));
        btns = pat;
        tick($urandom_range(1, 7));
      end
    end
    btns = '0; tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
